// File: rtl/hop1_lane_monitor.sv
// Four-lane first-rise / edge-count capture monitor for the hop stage outputs.
// Optional one-cycle completion pulse on irq when HOP1_MON_IRQ_EN is defined.
//
// state | meaning
// IDLE  | after reset, waiting for arm
// WAIT  | capture window open, counting rises
// DONE  | results frozen, arm restarts capture
module hop1_lane_monitor #(
  parameter int CNT_W   = 8,
  parameter int ARR_W   = 5,
  parameter int TIMEOUT = 20
) (
  input  logic               clock0,
  input  logic               rst1,
  input  logic               arm,
  input  logic [3:0]         lane_in,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [3:0]         lane_seen,
  output logic [4*ARR_W-1:0] arrive,
  output logic [4*CNT_W-1:0] edge_cnt,
  output logic [ARR_W-1:0]   skew
`ifdef HOP1_MON_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [3:0]         lane_prev_q, lane_prev_d;
  logic [ARR_W-1:0]   wcnt_q, wcnt_d;
  logic [3:0]         lane_seen_q, lane_seen_d;
  logic [4*ARR_W-1:0] arrive_q, arrive_d;
  logic [4*CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [ARR_W-1:0]   skew_q, skew_d;
  logic               timed_out_q, timed_out_d;
`ifdef HOP1_MON_IRQ_EN
  logic               irq_q, irq_d;
`endif

  logic [3:0]       rise;
  logic [3:0]       seen_next;
  logic             complete;
  logic [ARR_W-1:0] a_max, a_min, a_cur;

  assign rise = lane_in & ~lane_prev_q;

  always_comb begin
    state_d     = state_q;
    lane_prev_d = lane_in;
    wcnt_d      = wcnt_q;
    lane_seen_d = lane_seen_q;
    arrive_d    = arrive_q;
    edge_cnt_d  = edge_cnt_q;
    skew_d      = skew_q;
    timed_out_d = timed_out_q;
    seen_next   = lane_seen_q | rise;
    complete    = 1'b0;
`ifdef HOP1_MON_IRQ_EN
    irq_d       = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d     = ST_WAIT;
          wcnt_d      = '0;
          lane_seen_d = '0;
          arrive_d    = '0;
          edge_cnt_d  = '0;
          skew_d      = '0;
          timed_out_d = 1'b0;
        end
      end
      ST_WAIT: begin
        for (int i = 0; i < 4; i++) begin
          if (rise[i]) begin
            if (edge_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
              edge_cnt_d[i*CNT_W +: CNT_W] = edge_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            if (!lane_seen_q[i])
              arrive_d[i*ARR_W +: ARR_W] = wcnt_q;
          end
        end
        lane_seen_d = seen_next;
        if (seen_next == 4'hF) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b0;
          complete    = 1'b1;
`ifdef HOP1_MON_IRQ_EN
          irq_d       = 1'b1;
`endif
        end else if (wcnt_q == ARR_W'(TIMEOUT)) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
          skew_d      = '0;
`ifdef HOP1_MON_IRQ_EN
          irq_d       = 1'b1;
`endif
        end else begin
          wcnt_d = wcnt_q + ARR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Skew uses the arrival set including rises landing in the completing cycle.
    a_max = '0;
    a_min = '1;
    a_cur = '0;
    for (int i = 0; i < 4; i++) begin
      a_cur = arrive_d[i*ARR_W +: ARR_W];
      if (a_cur > a_max) a_max = a_cur;
      if (a_cur < a_min) a_min = a_cur;
    end
    if (complete) skew_d = a_max - a_min;
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state_q     <= ST_IDLE;
      lane_prev_q <= '0;
      wcnt_q      <= '0;
      lane_seen_q <= '0;
      arrive_q    <= '0;
      edge_cnt_q  <= '0;
      skew_q      <= '0;
      timed_out_q <= 1'b0;
`ifdef HOP1_MON_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lane_prev_q <= lane_prev_d;
      wcnt_q      <= wcnt_d;
      lane_seen_q <= lane_seen_d;
      arrive_q    <= arrive_d;
      edge_cnt_q  <= edge_cnt_d;
      skew_q      <= skew_d;
      timed_out_q <= timed_out_d;
`ifdef HOP1_MON_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign busy      = (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign timed_out = timed_out_q;
  assign lane_seen = lane_seen_q;
  assign arrive    = arrive_q;
  assign edge_cnt  = edge_cnt_q;
  assign skew      = skew_q;
`ifdef HOP1_MON_IRQ_EN
  assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_hop1_lane_monitor.sv
// Bench for hop1_lane_monitor: directed plan cases plus random lane patterns
// checked against a per-window-index list model of the capture rules.
module tb_hop1_lane_monitor;

  localparam int CNT_W   = 8;
  localparam int ARR_W   = 5;
  localparam int TIMEOUT = 20;

  logic               clock0 = 1'b0;
  logic               rst1   = 1'b1;
  logic               arm    = 1'b0;
  logic [3:0]         lane_in = 4'h0;
  logic               busy, done, timed_out;
  logic [3:0]         lane_seen;
  logic [4*ARR_W-1:0] arrive;
  logic [4*CNT_W-1:0] edge_cnt;
  logic [ARR_W-1:0]   skew;
`ifdef HOP1_MON_IRQ_EN
  logic               irq;
`endif

  hop1_lane_monitor #(.CNT_W(CNT_W), .ARR_W(ARR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock0    (clock0),
    .rst1      (rst1),
    .arm       (arm),
    .lane_in   (lane_in),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out),
    .lane_seen (lane_seen),
    .arrive    (arrive),
    .edge_cnt  (edge_cnt),
    .skew      (skew)
`ifdef HOP1_MON_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clock0 = ~clock0;

  int n_chk = 0;
  int n_bad = 0;

  logic [3:0] pat [0:TIMEOUT];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock0);
    #1;
  endtask

  // One capture: arm with 'pre' on the lanes, then pat[k] at window index k.
  task automatic run_capture(input logic [3:0] pre, input bit rand_arm, input string nm);
    int prev_lvl [4];
    int first [4];
    int cnt [4];
    int kc, exp_to, exp_skew, exp_seen, got, hi, lo, lvl;
    for (int i = 0; i < 4; i++) begin
      prev_lvl[i] = pre[i];
      first[i] = -1;
      cnt[i] = 0;
    end
    kc = TIMEOUT;
    exp_to = 1;
    for (int k = 0; k <= TIMEOUT; k++) begin
      int nseen;
      nseen = 0;
      for (int i = 0; i < 4; i++) begin
        lvl = pat[k][i];
        if (lvl == 1 && prev_lvl[i] == 0) begin
          cnt[i] = (cnt[i] < 255) ? cnt[i] + 1 : 255;
          if (first[i] < 0) first[i] = k;
        end
        prev_lvl[i] = lvl;
        if (first[i] >= 0) nseen++;
      end
      if (nseen == 4) begin
        kc = k;
        exp_to = 0;
        break;
      end
    end
    exp_seen = 0;
    hi = 0;
    lo = 1 << ARR_W;
    for (int i = 0; i < 4; i++) begin
      if (first[i] >= 0) exp_seen += (1 << i);
      if (first[i] > hi) hi = first[i];
      if (first[i] >= 0 && first[i] < lo) lo = first[i];
    end
    exp_skew = exp_to ? 0 : hi - lo;

    lane_in = pre;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk({nm, ".busy_arm"}, busy, 1);
    got = -1;
    for (int k = 0; k <= TIMEOUT + 2; k++) begin
      lane_in = (k <= TIMEOUT) ? pat[k] : 4'h0;
      arm = rand_arm ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (done) begin
        got = k;
        break;
      end
    end
    arm = 1'b0;
    chk({nm, ".done_idx"}, got, kc);
    chk({nm, ".timed_out"}, timed_out, exp_to);
    chk({nm, ".lane_seen"}, lane_seen, exp_seen);
    chk({nm, ".skew"}, skew, exp_skew);
    chk({nm, ".busy_done"}, busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.arrive%0d", nm, i), arrive[i*ARR_W +: ARR_W],
          (first[i] < 0) ? 0 : first[i]);
      chk($sformatf("%s.edge_cnt%0d", nm, i), edge_cnt[i*CNT_W +: CNT_W], cnt[i]);
    end
`ifdef HOP1_MON_IRQ_EN
    chk({nm, ".irq_on"}, irq, 1);
`endif
    lane_in = 4'($urandom);
    tick();
    lane_in = 4'($urandom);
    tick();
    chk({nm, ".hold_done"}, done, 1);
    chk({nm, ".hold_seen"}, lane_seen, exp_seen);
    chk({nm, ".hold_cnt0"}, edge_cnt[0 +: CNT_W], cnt[0]);
`ifdef HOP1_MON_IRQ_EN
    chk({nm, ".irq_off"}, irq, 0);
`endif
  endtask

  initial begin
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.timed_out", timed_out, 0);
    chk("rst.lane_seen", lane_seen, 0);
    chk("rst.arrive", int'(arrive), 0);
    chk("rst.edge_cnt", int'(edge_cnt), 0);
    chk("rst.skew", skew, 0);
`ifdef HOP1_MON_IRQ_EN
    chk("rst.irq", irq, 0);
`endif
    rst1 = 1'b0;
    tick();

    for (int k = 0; k <= TIMEOUT; k++)
      pat[k] = {4'(k >= 9), 4'(k >= 5), 4'(k >= 3), 4'(k >= 2)} == 4'h0 ? 4'h0
             : {k >= 9, k >= 5, k >= 3, k >= 2};
    run_capture(4'h0, 1'b1, "order");

    for (int k = 0; k <= TIMEOUT; k++) pat[k] = (k >= 1) ? 4'h7 : 4'h0;
    run_capture(4'h0, 1'b0, "three");

    for (int k = 0; k <= TIMEOUT; k++) pat[k] = (k % 2 == 0) ? 4'h2 : 4'h0;
    run_capture(4'h0, 1'b0, "toggle");

    for (int k = 0; k <= TIMEOUT; k++) pat[k] = 4'hF;
    run_capture(4'hF, 1'b0, "prehigh");

    for (int k = 0; k <= TIMEOUT; k++) pat[k] = (k >= 6) ? 4'hF : 4'h0;
    run_capture(4'h0, 1'b0, "same6");
    run_capture(4'h0, 1'b0, "rearm6");

    // Reset in the middle of a capture after lanes 0 and 1 have risen.
    lane_in = 4'h0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lane_in = (k >= 1) ? 4'h3 : 4'h0;
      tick();
    end
    chk("midrst.pre_seen", lane_seen, 3);
    #1 rst1 = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.lane_seen", lane_seen, 0);
    chk("midrst.arrive", int'(arrive), 0);
    chk("midrst.edge_cnt", int'(edge_cnt), 0);
    tick();
    rst1 = 1'b0;
    lane_in = 4'h0;
    tick();
    for (int k = 0; k <= TIMEOUT; k++) pat[k] = (k >= 4) ? 4'hB : ((k >= 2) ? 4'h4 : 4'h0);
    run_capture(4'h0, 1'b0, "postrst");

    for (int r = 0; r < 30; r++) begin
      int p [4];
      for (int i = 0; i < 4; i++) p[i] = $urandom_range(0, 100);
      for (int k = 0; k <= TIMEOUT; k++)
        for (int i = 0; i < 4; i++)
          pat[k][i] = ($urandom_range(0, 99) < p[i]);
      run_capture(4'($urandom), 1'b1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
